// File: rtl/spi_transaction_fsm_pkg.sv
// Shared definitions for the SPI memory-slave transaction controller:
// state encodings and the R/W bit polarity.
package spi_transaction_fsm_pkg;

    typedef enum logic [3:0] {
        StIdle        = 4'd0,
        StGet         = 4'd1,
        StGot         = 4'd2,
        StReadWait    = 4'd3,
        StReadLoad    = 4'd4,
        StReadShift   = 4'd5,
        StWriteGet    = 4'd6,
        StWriteCommit = 4'd7,
        StDone        = 4'd8
    } state_e;

    localparam logic RwRead = 1'b1;

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter: synchronous clear has priority over increment, and the
// count saturates at WIDTH so it never wraps inside a frame.
module spi_bit_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(WIDTH);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MaxCnt)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_transaction_fsm.sv
// Transaction sequencer for the SPI memory slave: address frame, then either a
// memory write or a shift-register load followed by MISO drive for the read frame.
module spi_transaction_fsm
    import spi_transaction_fsm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       csConditioned,
    input  logic       sclkPosEdge,
    input  logic       sclkNegEdge,
    input  logic       rwBit,
    output logic       addrWe,
    output logic       dmWe,
    output logic       srWe,
    output logic       misoBufferEn,
    output logic [3:0] state
);

    // A frame ends on the strobe that takes the count from WIDTH-1 to WIDTH.
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_d;
    state_e           state_q;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;

    logic addr_we_q;
    logic dm_we_q;
    logic sr_we_q;
    logic miso_en_q;

    spi_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .count   (cnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        // Chip-select release aborts from anywhere and beats every other transition.
        if ((state_q != StIdle) && csConditioned) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_clear = 1'b1;
                    if (!csConditioned) begin
                        state_d = StGet;
                    end
                end
                StGet: begin
                    if (sclkPosEdge) begin
                        cnt_inc = 1'b1;
                        if (cnt == LastCnt) begin
                            state_d = StGot;
                        end
                    end
                end
                StGot: begin
                    cnt_clear = 1'b1;
                    state_d   = (rwBit == RwRead) ? StReadWait : StWriteGet;
                end
                StReadWait: begin
                    state_d = StReadLoad;
                end
                StReadLoad: begin
                    cnt_clear = 1'b1;
                    state_d   = StReadShift;
                end
                StReadShift: begin
                    if (sclkNegEdge) begin
                        cnt_inc = 1'b1;
                        if (cnt == LastCnt) begin
                            state_d = StDone;
                        end
                    end
                end
                StWriteGet: begin
                    if (sclkPosEdge) begin
                        cnt_inc = 1'b1;
                        if (cnt == LastCnt) begin
                            state_d = StWriteCommit;
                        end
                    end
                end
                StWriteCommit: begin
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d   = StIdle;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so they track state_q exactly (Moore).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_we_q <= 1'b0;
            dm_we_q   <= 1'b0;
            sr_we_q   <= 1'b0;
            miso_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_we_q <= (state_d == StGot);
            dm_we_q   <= (state_d == StWriteCommit);
            sr_we_q   <= (state_d == StReadLoad);
            miso_en_q <= (state_d == StReadShift);
        end
    end

    assign addrWe       = addr_we_q;
    assign dmWe         = dm_we_q;
    assign srWe         = sr_we_q;
    assign misoBufferEn = miso_en_q;
    assign state        = state_q;

endmodule
